// File: rtl/z80_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_arbiter
// Purpose  : Arbitrates Z80 bus mastership among an external master (via the
//            /BUSRQ and /BUSAK pads) and an internal DMA master. It requests
//            the bus from the CPU core, grants it to the selected owner, and
//            steers the pad mux (float for external, DMA drive for internal).
// Ports    : wb_clk_i     - sole clock, rising edge
//            rst_n        - synchronous active-low reset
//            pin_busrq_n  - external /BUSRQ pad (asynchronous, synchronized)
//            pin_busak_n  - external /BUSAK pad drive (0 = external owns bus)
//            core_busrq_n - bus request to the CPU core
//            core_busak_n - bus acknowledge from the CPU core
//            dma_req      - internal DMA request (level)
//            dma_gnt      - internal DMA grant
//            bus_float    - 1 = pad mux floats address, data and strobes
//            bus_sel_dma  - 1 = pad mux drives pads from the DMA master
//            arb_err      - sticky acknowledge-timeout flag
// Config   : define Z80_ARB_TIMEOUT_EN to build the 8-bit acknowledge timeout;
//            without it arb_err is tied low and REQ waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module z80_bus_arbiter (
  input  logic wb_clk_i,
  input  logic rst_n,
  input  logic pin_busrq_n,
  output logic pin_busak_n,
  output logic core_busrq_n,
  input  logic core_busak_n,
  input  logic dma_req,
  output logic dma_gnt,
  output logic bus_float,
  output logic bus_sel_dma,
  output logic arb_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GNT_EXT = 3'd2,
    GNT_INT = 3'd3,
    REL     = 3'd4
  } state_t;

  localparam logic OWNER_INT = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  // --------------------------------------------------------------------------
  // /BUSRQ pad synchronizer; flops idle high (no request).
  // --------------------------------------------------------------------------
  logic sync_meta;
  logic sync_out;
  logic ext_req;

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync_out  <= 1'b1;
    end else begin
      sync_meta <= pin_busrq_n;
      sync_out  <= sync_meta;
    end
  end

  assign ext_req = ~sync_out;

  // --------------------------------------------------------------------------
  // Arbitration state
  // --------------------------------------------------------------------------
  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   owner_nxt;
  logic   last_owner;
  logic   last_owner_nxt;
  logic   pick;
  logic   owner_req;
  logic   timeout_hit;

  // Single requester wins outright; on a tie the one not granted last wins.
  always_comb begin
    pick = OWNER_INT;
    if (ext_req && dma_req) begin
      pick = ~last_owner;
    end else if (ext_req) begin
      pick = OWNER_EXT;
    end
  end

  assign owner_req = (owner == OWNER_EXT) ? ext_req : dma_req;

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWNER_INT;
      last_owner <= OWNER_INT;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Requests arriving while granted or releasing simply stay pending as
  // levels; they are only picked up again from IDLE.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (ext_req || dma_req) begin
          state_nxt = REQ;
          owner_nxt = pick;
        end
      end
      REQ: begin
        // Acknowledge takes precedence over a withdrawal or timeout seen on
        // the same edge; the core already handed over the bus.
        if (!core_busak_n) begin
          state_nxt      = (owner == OWNER_EXT) ? GNT_EXT : GNT_INT;
          last_owner_nxt = owner;
        end else if (!owner_req || timeout_hit) begin
          state_nxt = REL;
        end
      end
      GNT_EXT: begin
        if (!ext_req) begin
          state_nxt = REL;
        end
      end
      GNT_INT: begin
        if (!dma_req) begin
          state_nxt = REL;
        end
      end
      REL: begin
        if (core_busak_n) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs registered from the next state so they switch on the same edge
  // as the state transition.
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      core_busrq_n <= 1'b1;
      pin_busak_n  <= 1'b1;
      dma_gnt      <= 1'b0;
      bus_float    <= 1'b0;
      bus_sel_dma  <= 1'b0;
    end else begin
      core_busrq_n <= ~((state_nxt == REQ) || (state_nxt == GNT_EXT) ||
                        (state_nxt == GNT_INT));
      pin_busak_n  <= ~(state_nxt == GNT_EXT);
      dma_gnt      <= (state_nxt == GNT_INT);
      bus_float    <= (state_nxt == GNT_EXT);
      bus_sel_dma  <= (state_nxt == GNT_INT);
    end
  end

  // --------------------------------------------------------------------------
  // Optional acknowledge timeout
  // --------------------------------------------------------------------------
`ifdef Z80_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       err_q;

  // Counter is held at zero outside REQ, so it starts from zero on entry.
  // After 255 edges in REQ it would reach 255; the REQ exit fires on the
  // edge that takes it there.
  assign timeout_hit = (state == REQ) && (to_cnt == 8'd254);

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      to_cnt <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      if (state != REQ) begin
        to_cnt <= 8'd0;
      end else begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (timeout_hit && core_busak_n) begin
        err_q <= 1'b1;
      end
    end
  end

  assign arb_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign arb_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_bus_arbiter
// Purpose  : Directed self-checking bench for z80_bus_arbiter. Inputs change
//            1 time unit after a rising edge; outputs are sampled there too.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80_bus_arbiter;

  logic wb_clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic pin_busrq_n = 1'b1;
  logic pin_busak_n;
  logic core_busrq_n;
  logic core_busak_n = 1'b1;
  logic dma_req = 1'b0;
  logic dma_gnt;
  logic bus_float;
  logic bus_sel_dma;
  logic arb_err;

  int total = 0;
  int passed = 0;

  // {core_busrq_n, pin_busak_n, dma_gnt, bus_float, bus_sel_dma, arb_err}
  localparam logic [5:0] O_IDLE = 6'b110000;  // also REL
  localparam logic [5:0] O_REQ  = 6'b010000;
  localparam logic [5:0] O_GEXT = 6'b000100;
  localparam logic [5:0] O_GINT = 6'b011010;
  localparam logic [5:0] O_TERR = 6'b110001;

  logic [5:0] outs;
  assign outs = {core_busrq_n, pin_busak_n, dma_gnt, bus_float, bus_sel_dma, arb_err};

  always #5 wb_clk_i = ~wb_clk_i;

  z80_bus_arbiter dut (
    .wb_clk_i     (wb_clk_i),
    .rst_n        (rst_n),
    .pin_busrq_n  (pin_busrq_n),
    .pin_busak_n  (pin_busak_n),
    .core_busrq_n (core_busrq_n),
    .core_busak_n (core_busak_n),
    .dma_req      (dma_req),
    .dma_gnt      (dma_gnt),
    .bus_float    (bus_float),
    .bus_sel_dma  (bus_sel_dma),
    .arb_err      (arb_err)
  );

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance one edge; the mutual-exclusion properties are checked every cycle.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    chk("excl", {4'b0, bus_float & bus_sel_dma, dma_gnt & ~pin_busak_n}, 6'b0);
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    chk("reset_vals", outs, O_IDLE);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", outs, O_IDLE);

    // ---------------- external only ----------------
    pin_busrq_n = 1'b0;
    tick(); tick();
    chk("ext_sync_delay", outs, O_IDLE);
    tick();
    chk("ext_req_state", outs, O_REQ);
    tick(); tick(); tick();
    chk("ext_wait_ack", outs, O_REQ);
    core_busak_n = 1'b0;
    tick();
    chk("ext_grant", outs, O_GEXT);
    tick();
    chk("ext_grant_hold", outs, O_GEXT);
    pin_busrq_n = 1'b1;
    tick(); tick();
    chk("ext_drop_sync", outs, O_GEXT);
    tick();
    chk("ext_rel", outs, O_IDLE);
    // New DMA request while REL waits for the core: must stay pending.
    dma_req = 1'b1;
    tick();
    chk("rel_holds_pending", outs, O_IDLE);
    core_busak_n = 1'b1;
    tick();
    chk("rel_to_idle", outs, O_IDLE);
    tick();
    chk("dma_req_state", outs, O_REQ);

    // ---------------- DMA only ----------------
    tick();
    chk("dma_wait_ack", outs, O_REQ);
    core_busak_n = 1'b0;
    tick();
    chk("dma_grant", outs, O_GINT);
    tick();
    chk("dma_grant_hold", outs, O_GINT);
    dma_req = 1'b0;
    tick();
    chk("dma_release_1cyc", outs, O_IDLE);
    core_busak_n = 1'b1;
    tick(); tick();
    chk("dma_idle", outs, O_IDLE);

    // ---------------- tie arbitration after reset ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pin_busrq_n = 1'b0;
    tick(); tick();
    dma_req = 1'b1;
    tick();
    chk("tie1_req", outs, O_REQ);
    core_busak_n = 1'b0;
    tick();
    chk("tie1_ext_wins", outs, O_GEXT);
    pin_busrq_n = 1'b1;
    tick();
    pin_busrq_n = 1'b0;  // pulse just long enough to drop ext_req once
    tick();
    chk("tie1_hold", outs, O_GEXT);
    tick();
    chk("tie1_rel", outs, O_IDLE);
    core_busak_n = 1'b1;
    tick();
    chk("tie2_idle", outs, O_IDLE);
    tick();
    chk("tie2_req", outs, O_REQ);
    core_busak_n = 1'b0;
    tick();
    chk("tie2_dma_wins", outs, O_GINT);
    dma_req = 1'b0;
    tick();
    chk("tie2_rel", outs, O_IDLE);
    dma_req = 1'b1;
    core_busak_n = 1'b1;
    tick(); tick();
    chk("tie3_req", outs, O_REQ);
    core_busak_n = 1'b0;
    tick();
    chk("tie3_ext_wins", outs, O_GEXT);

    // ---------------- reset during GNT_EXT ----------------
    rst_n = 1'b0;
    tick();
    chk("reset_mid_grant", outs, O_IDLE);
    rst_n = 1'b1;
    pin_busrq_n = 1'b1;
    dma_req = 1'b0;
    core_busak_n = 1'b1;
    tick(); tick(); tick();
    chk("post_reset_idle", outs, O_IDLE);

    // ---------------- withdraw in REQ ----------------
    dma_req = 1'b1;
    tick();
    chk("wd_req", outs, O_REQ);
    dma_req = 1'b0;
    tick();
    chk("wd_rel_no_gnt", outs, O_IDLE);
    core_busak_n = 1'b0;  // late acknowledge
    dma_req = 1'b1;
    tick();
    chk("wd_late_ack_rel", outs, O_IDLE);
    tick();
    chk("wd_late_ack_hold", outs, O_IDLE);
    core_busak_n = 1'b1;
    tick();
    chk("wd_idle", outs, O_IDLE);
    tick();
    chk("wd_rerequest", outs, O_REQ);
    dma_req = 1'b0;
    tick(); tick();
    chk("wd_done", outs, O_IDLE);

    // ---------------- acknowledge timeout ----------------
    dma_req = 1'b1;
    tick();
    chk("to_req_entry", outs, O_REQ);
`ifdef Z80_ARB_TIMEOUT_EN
    for (int i = 0; i < 254; i++) tick();
    chk("to_before_expiry", outs, O_REQ);
    tick();
    chk("to_expired", outs, O_TERR);
    dma_req = 1'b0;
    tick(); tick();
    chk("to_err_sticky", outs, O_TERR);
`else
    for (int i = 0; i < 1000; i++) tick();
    chk("no_timeout", outs, O_REQ);
    core_busak_n = 1'b0;
    tick();
    chk("no_timeout_grant", outs, O_GINT);
    dma_req = 1'b0;
    tick();
    chk("no_timeout_rel", outs, O_IDLE);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
